// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO bank.
//   - Register addresses for the 3-bit address bus (ADDR_OUT .. ADDR_IRQ_STAT).
//   - Default parameter values for pin count and synchronizer depth.
package gpio_pkg;

    localparam int GPIO_DEFAULT_WIDTH       = 8;
    localparam int GPIO_DEFAULT_SYNC_STAGES = 2;

    localparam logic [2:0] ADDR_OUT      = 3'd0;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd1;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd2;
    localparam logic [2:0] ADDR_OUT_TGL  = 3'd3;
    localparam logic [2:0] ADDR_DIR      = 3'd4;
    localparam logic [2:0] ADDR_IN       = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd6;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-flop synchronizer chain for asynchronous pin inputs.
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset, clears every stage
//   din  - asynchronous input bits (WIDTH)
//   dout - synchronized output, the last stage of the chain (WIDTH)
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] sync_d;
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Stage 0 captures the raw pins; each later stage copies its predecessor.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: register-mapped GPIO bank with rising-edge interrupts.
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset
//   we       - write strobe
//   addr     - register address (read and write)
//   wdata    - write data (WIDTH)
//   rdata    - registered read data, one cycle after addr (WIDTH)
//   gpio_in  - asynchronous pin inputs (WIDTH)
//   gpio_out - output data register (WIDTH)
//   gpio_oe  - per-pin output enable, 1 = drive (WIDTH)
//   irq      - registered level interrupt, OR of enabled status bits
// Register map: 0 OUT, 1 OUT_SET, 2 OUT_CLR, 3 OUT_TGL, 4 DIR, 5 IN (read-only),
// 6 IRQ_EN, 7 IRQ_STAT (sticky, write-1-to-clear). Addresses 1..3 read as 0.
// SYNC_STAGES must be in the range 2..4.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = GPIO_DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    // Edge detection stays off for the first SYNC_STAGES+1 edges after reset,
    // while the synchronizer and edge history still hold reset zeros.
    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int WARM_W   = $clog2(WARM_MAX + 1);

    logic [WIDTH-1:0]  in_sync;
    logic [WIDTH-1:0]  rise;
    logic              warm_done;

    logic [WIDTH-1:0]  out_d,   out_q;
    logic [WIDTH-1:0]  dir_d,   dir_q;
    logic [WIDTH-1:0]  en_d,    en_q;
    logic [WIDTH-1:0]  stat_d,  stat_q;
    logic [WIDTH-1:0]  prev_d,  prev_q;
    logic [WIDTH-1:0]  rdata_d, rdata_q;
    logic              irq_d,   irq_q;
    logic [WARM_W-1:0] warm_d,  warm_q;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (gpio_in),
        .dout (in_sync)
    );

    assign warm_done = (warm_q == WARM_W'(WARM_MAX));

    always_comb begin
        rise   = warm_done ? (in_sync & ~prev_q) : '0;
        prev_d = in_sync;
        warm_d = warm_done ? warm_q : (warm_q + WARM_W'(1));

        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        stat_d = stat_q;

        if (we) begin
            case (addr)
                ADDR_OUT:      out_d  = wdata;
                ADDR_OUT_SET:  out_d  = out_q | wdata;
                ADDR_OUT_CLR:  out_d  = out_q & ~wdata;
                ADDR_OUT_TGL:  out_d  = out_q ^ wdata;
                ADDR_DIR:      dir_d  = wdata;
                ADDR_IRQ_EN:   en_d   = wdata;
                ADDR_IRQ_STAT: stat_d = stat_q & ~wdata;
                default:       ;
            endcase
        end

        // Applied after the W1C so a simultaneous edge keeps the bit set.
        stat_d = stat_d | rise;

        // Read mux uses current register values, so a same-cycle write is not seen.
        case (addr)
            ADDR_OUT:      rdata_d = out_q;
            ADDR_DIR:      rdata_d = dir_q;
            ADDR_IN:       rdata_d = in_sync;
            ADDR_IRQ_EN:   rdata_d = en_q;
            ADDR_IRQ_STAT: rdata_d = stat_q;
            default:       rdata_d = '0;
        endcase

        irq_d = |(stat_q & en_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            en_q    <= '0;
            stat_q  <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            warm_q  <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            stat_q  <= stat_d;
            prev_q  <= prev_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            warm_q  <= warm_d;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign rdata    = rdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed scenarios plus randomized traffic for gpio_bank.
// A reference model tracks the register file and treats the pin path as a
// delay line of clock-edge samples; outputs are sampled on the falling edge.
module tb_gpio_bank;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         we = 1'b0;
    logic [2:0]   addr = 3'd0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] rdata;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    int total = 0;
    int bad   = 0;

    gpio_bank #(
        .WIDTH       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_out, m_dir, m_en, m_stat, m_rdata;
    logic         m_irq;
    logic [W-1:0] hist[$];      // hist[0] = most recent pin sample
    int           m_cyc;        // edges seen since reset release
    logic [W-1:0] m_now, m_prev, m_rise;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_rdata = '0;
            m_irq = 1'b0;
            m_cyc = 0;
            hist.delete();
            for (int i = 0; i <= SS; i++) hist.push_front('0);
        end else begin
            // Pins become visible SS edges after sampling.
            m_now  = hist[SS-1];
            m_prev = hist[SS];
            m_rise = (m_cyc >= SS + 1) ? (m_now & ~m_prev) : '0;
            case (addr)
                3'd0:    m_rdata = m_out;
                3'd4:    m_rdata = m_dir;
                3'd5:    m_rdata = m_now;
                3'd6:    m_rdata = m_en;
                3'd7:    m_rdata = m_stat;
                default: m_rdata = '0;
            endcase
            m_irq = |(m_stat & m_en);
            if (we) begin
                case (addr)
                    3'd0:    m_out = wdata;
                    3'd1:    m_out = m_out | wdata;
                    3'd2:    m_out = m_out & ~wdata;
                    3'd3:    m_out = m_out ^ wdata;
                    3'd4:    m_dir = wdata;
                    3'd6:    m_en = wdata;
                    3'd7:    m_stat = m_stat & ~wdata;
                    default: ;
                endcase
            end
            m_stat = m_stat | m_rise;
            hist.push_front(gpio_in);
            void'(hist.pop_back());
            if (m_cyc < 100000) m_cyc++;
        end
    end

    // ---------------- driver ----------------
    task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        gpio_in = '1; we = 1'b0; addr = 3'd7;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({gpio_out, gpio_oe, irq, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got out=%h oe=%h irq=%b rdata=%h want all 0", gpio_out, gpio_oe, irq, rdata);
        end
        rst = 1'b0;
        for (int i = 0; i < 3 * SS + 2; i++) begin
            @(negedge clk);
            total++;
            if (rdata !== 8'h00 || irq !== 1'b0 || gpio_out !== 8'h00 || gpio_oe !== 8'h00) begin
                bad++;
                $display("FAIL reset_warmup cyc%0d: got stat=%h irq=%b out=%h oe=%h want 0", i, rdata, irq, gpio_out, gpio_oe);
            end
            total++;
            if ({gpio_out, gpio_oe, irq, rdata} !== {m_out, m_dir, m_irq, m_rdata}) begin
                bad++;
                $display("FAIL reset_model cyc%0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, gpio_out, gpio_oe, irq, rdata, m_out, m_dir, m_irq, m_rdata);
            end
        end
        addr = 3'd5;
        @(negedge clk);
        total++;
        if (rdata !== 8'hFF) begin
            bad++;
            $display("FAIL reset_in_read: got %h want ff", rdata);
        end
    endtask

    task automatic test_read_collision();
        we = 1'b1; addr = 3'd4; wdata = 8'h3C;
        @(negedge clk);
        we = 1'b0;
        total++;
        if (rdata !== 8'h00) begin
            bad++;
            $display("FAIL collision_old_read: got %h want 00", rdata);
        end
        total++;
        if (gpio_oe !== 8'h3C) begin
            bad++;
            $display("FAIL collision_oe: got %h want 3c", gpio_oe);
        end
        @(negedge clk);
        total++;
        if (rdata !== 8'h3C) begin
            bad++;
            $display("FAIL collision_new_read: got %h want 3c", rdata);
        end
    endtask

    task automatic test_output_ops();
        logic [2:0]   op_a [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [W-1:0] op_d [4] = '{8'hA5, 8'h0A, 8'h81, 8'hFF};
        logic [W-1:0] op_e [4] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
        for (int i = 0; i < 4; i++) begin
            do_write(op_a[i], op_d[i]);
            total++;
            if (gpio_out !== op_e[i]) begin
                bad++;
                $display("FAIL output_op%0d: got %h want %h", i, gpio_out, op_e[i]);
            end
        end
        addr = 3'd1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rdata !== 8'h00) begin
            bad++;
            $display("FAIL read_set_addr: got %h want 00", rdata);
        end
    endtask

    task automatic test_edge_irq();
        addr = 3'd7; gpio_in = '0;
        repeat (SS + 2) @(negedge clk);
        do_write(3'd7, 8'hFF);
        do_write(3'd6, 8'h04);
        addr = 3'd7;
        gpio_in[2] = 1'b1;
        repeat (SS + 1) @(negedge clk);
        total++;
        if (irq !== 1'b0 || rdata !== 8'h00) begin
            bad++;
            $display("FAIL edge_early: got irq=%b stat=%h want 0/00", irq, rdata);
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b1 || rdata !== 8'h04) begin
            bad++;
            $display("FAIL edge_set: got irq=%b stat=%h want 1/04", irq, rdata);
        end
        do_write(3'd7, 8'h04);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_hold: got irq=%b want 1", irq);
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b0 || rdata !== 8'h00) begin
            bad++;
            $display("FAIL w1c_drop: got irq=%b stat=%h want 0/00", irq, rdata);
        end
    endtask

    task automatic test_set_wins();
        addr = 3'd7;
        gpio_in[0] = 1'b1;
        repeat (SS) @(negedge clk);
        we = 1'b1; wdata = 8'h01;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        total++;
        if (rdata !== 8'h01) begin
            bad++;
            $display("FAIL set_wins: got stat=%h want 01", rdata);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            total++;
            if ({gpio_out, gpio_oe, irq, rdata} !== {m_out, m_dir, m_irq, m_rdata}) begin
                bad++;
                $display("FAIL random cyc%0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, gpio_out, gpio_oe, irq, rdata, m_out, m_dir, m_irq, m_rdata);
            end
            we    = 1'($urandom_range(0, 1));
            addr  = 3'($urandom_range(0, 7));
            wdata = W'($urandom);
            if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
        end
        we = 1'b0;
    endtask

    task automatic test_async_reset();
        do_write(3'd0, 8'hFF);
        do_write(3'd6, 8'hFF);
        gpio_in = '0;
        repeat (SS + 2) @(negedge clk);
        gpio_in = '1;
        repeat (SS + 3) @(negedge clk);
        total++;
        if (gpio_out !== 8'hFF || irq !== 1'b1) begin
            bad++;
            $display("FAIL async_pre: got out=%h irq=%b want ff/1", gpio_out, irq);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (gpio_out !== 8'h00 || irq !== 1'b0 || rdata !== 8'h00 || gpio_oe !== 8'h00) begin
            bad++;
            $display("FAIL async_clear: got out=%h irq=%b rdata=%h oe=%h want 0", gpio_out, irq, rdata, gpio_oe);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; addr = 3'd7;
        for (int i = 0; i < SS + 4; i++) begin
            @(negedge clk);
            total++;
            if (rdata !== 8'h00 || {gpio_out, gpio_oe, irq, rdata} !== {m_out, m_dir, m_irq, m_rdata}) begin
                bad++;
                $display("FAIL async_warmup cyc%0d: got %h/%h/%b/%h want %h/%h/%b/00", i, gpio_out, gpio_oe, irq, rdata, m_out, m_dir, m_irq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_collision();
        test_output_ops();
        test_edge_irq();
        test_set_wins();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
